// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port between COUNT requesters,
// with a free-running auto-refresh scheduler that takes priority over accesses.
module ram_arbiter #(
  parameter int unsigned COUNT         = 3,
  parameter int unsigned ADDR_WIDTH    = 23,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned RFSH_INTERVAL = 1620
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [COUNT-1:0]              REQ_VALID,
  input  logic [COUNT-1:0]              REQ_WE,
  input  logic [COUNT*ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [COUNT*DATA_WIDTH-1:0]   REQ_DIN,
  output logic [COUNT-1:0]              REQ_READY,
  output logic [COUNT-1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_DOUT,
  output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
  output logic [DATA_WIDTH-1:0]         MEM_DIN,
  output logic                          MEM_OE_n,
  output logic                          MEM_WE_n,
  output logic                          MEM_RFSH_n,
  input  logic [DATA_WIDTH-1:0]         MEM_DOUT,
  input  logic                          MEM_ACK
);

  localparam int unsigned IW = (COUNT > 2) ? 2 : 1;
  localparam int unsigned TW = $clog2(RFSH_INTERVAL);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

  state_t          state;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   last;
  logic [TW-1:0]   timer;
  logic [1:0]      rfsh_pend;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            wrap;
  logic            rfsh_ack;

  // Search starts one past the previous winner and wraps, giving round-robin order.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= COUNT; k++) begin
      idx = IW'((32'(last) + k) % COUNT);
      if (!found && REQ_VALID[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign wrap     = (timer == TW'(RFSH_INTERVAL - 1));
  assign rfsh_ack = (state == REFRESH) && MEM_ACK;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      gnt        <= '0;
      last       <= IW'(COUNT - 1);
      timer      <= '0;
      rfsh_pend  <= '0;
      REQ_READY  <= '0;
      RSP_VALID  <= '0;
      RSP_DOUT   <= '0;
      MEM_ADDR   <= '0;
      MEM_DIN    <= '0;
      MEM_OE_n   <= 1'b1;
      MEM_WE_n   <= 1'b1;
      MEM_RFSH_n <= 1'b1;
    end else begin
      REQ_READY <= '0;
      RSP_VALID <= '0;

      timer <= wrap ? '0 : timer + 1'b1;
      // A wrap landing on a refresh ack leaves the pending count untouched.
      if (wrap && !rfsh_ack) begin
        if (rfsh_pend != 2'd3) rfsh_pend <= rfsh_pend + 2'd1;
      end else if (!wrap && rfsh_ack) begin
        rfsh_pend <= rfsh_pend - 2'd1;
      end

      case (state)
        IDLE: begin
          if (rfsh_pend != 2'd0) begin
            state      <= REFRESH;
            MEM_RFSH_n <= 1'b0;
          end else if (found) begin
            state     <= ACCESS;
            gnt       <= win;
            last      <= win;
            REQ_READY <= COUNT'(1) << win;
            MEM_ADDR  <= REQ_ADDR[win*ADDR_WIDTH +: ADDR_WIDTH];
            MEM_DIN   <= REQ_DIN[win*DATA_WIDTH +: DATA_WIDTH];
            MEM_OE_n  <= REQ_WE[win];
            MEM_WE_n  <= ~REQ_WE[win];
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            state     <= IDLE;
            RSP_DOUT  <= MEM_DOUT;
            RSP_VALID <= COUNT'(1) << gnt;
            MEM_OE_n  <= 1'b1;
            MEM_WE_n  <= 1'b1;
          end
        end
        REFRESH: begin
          if (MEM_ACK) begin
            state      <= IDLE;
            MEM_RFSH_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a small SDRAM responder plus an event log of
// grants, responses and refresh starts, checked against hand-computed values.
module tb_ram_arbiter;

  localparam int unsigned COUNT = 3;
  localparam int unsigned AW    = 23;
  localparam int unsigned DW    = 16;
  localparam int unsigned RI    = 16;

  logic                 CLK;
  logic                 RESET;
  logic [COUNT-1:0]     REQ_VALID;
  logic [COUNT-1:0]     REQ_WE;
  logic [COUNT*AW-1:0]  REQ_ADDR;
  logic [COUNT*DW-1:0]  REQ_DIN;
  logic [COUNT-1:0]     REQ_READY;
  logic [COUNT-1:0]     RSP_VALID;
  logic [DW-1:0]        RSP_DOUT;
  logic [AW-1:0]        MEM_ADDR;
  logic [DW-1:0]        MEM_DIN;
  logic                 MEM_OE_n;
  logic                 MEM_WE_n;
  logic                 MEM_RFSH_n;
  logic [DW-1:0]        MEM_DOUT;
  logic                 MEM_ACK;

  ram_arbiter #(
    .COUNT(COUNT),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RFSH_INTERVAL(RI)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ_VALID(REQ_VALID),
    .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR),
    .REQ_DIN(REQ_DIN),
    .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID),
    .RSP_DOUT(RSP_DOUT),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DIN(MEM_DIN),
    .MEM_OE_n(MEM_OE_n),
    .MEM_WE_n(MEM_WE_n),
    .MEM_RFSH_n(MEM_RFSH_n),
    .MEM_DOUT(MEM_DOUT),
    .MEM_ACK(MEM_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: acks any active command after ack_delay cycles unless held.
  logic           hold;
  int unsigned    ack_delay;
  logic [DW-1:0]  rd_data;

  initial begin
    int unsigned cnt;
    cnt      = 0;
    MEM_ACK  = 1'b0;
    MEM_DOUT = '0;
    forever begin
      @(negedge CLK);
      MEM_ACK = 1'b0;
      if (!MEM_OE_n || !MEM_WE_n || !MEM_RFSH_n) begin
        if (!hold) begin
          cnt++;
          if (cnt >= ack_delay) begin
            MEM_ACK  = 1'b1;
            MEM_DOUT = rd_data;
            cnt      = 0;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Event log codes: i = grant to requester i, 10+i = response i, 20 = refresh start.
  int          evlog[$];
  int unsigned oe_last;

  initial begin
    int unsigned oe_cur;
    logic rfsh_prev;
    oe_cur    = 0;
    oe_last   = 0;
    rfsh_prev = 1'b1;
    forever begin
      @(negedge CLK);
      for (int unsigned i = 0; i < COUNT; i++) begin
        if (REQ_READY[i]) evlog.push_back(int'(i));
        if (RSP_VALID[i]) evlog.push_back(10 + int'(i));
      end
      if (!MEM_RFSH_n && rfsh_prev) evlog.push_back(20);
      rfsh_prev = MEM_RFSH_n;
      if (!MEM_OE_n) oe_cur++;
      else if (oe_cur != 0) begin
        oe_last = oe_cur;
        oe_cur  = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic set_req(input int unsigned i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    REQ_WE[i]          = we;
    REQ_ADDR[i*AW +: AW] = a;
    REQ_DIN[i*DW +: DW]  = d;
    REQ_VALID[i]       = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int unsigned i);
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (REQ_READY != '0) break;
    end
    check(tag, 32'(REQ_READY), 32'(COUNT'(1) << i));
    REQ_VALID[i] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int unsigned i);
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (RSP_VALID != '0) break;
    end
    check(tag, 32'(RSP_VALID), 32'(COUNT'(1) << i));
  endtask

  initial begin
    int grants[$];
    int exp_ev[5];
    int got_ev;
    int n_rfsh;

    RESET     = 1'b1;
    REQ_VALID = '0;
    REQ_WE    = '0;
    REQ_ADDR  = '0;
    REQ_DIN   = '0;
    hold      = 1'b0;
    ack_delay = 4;
    rd_data   = 16'hA55A;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(REQ_READY), 32'h0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    check("rst_rsp_dout", 32'(RSP_DOUT), 32'h0);
    check("rst_oe_n", 32'(MEM_OE_n), 32'h1);
    check("rst_we_n", 32'(MEM_WE_n), 32'h1);
    check("rst_rfsh_n", 32'(MEM_RFSH_n), 32'h1);
    check("rst_addr", 32'(MEM_ADDR), 32'h0);
    check("rst_din", 32'(MEM_DIN), 32'h0);

    // Single read by requester 0, ack 4 cycles after the command
    do_reset();
    set_req(0, 1'b0, 23'h000100, 16'h0);
    @(negedge CLK);
    check("rd_ready", 32'(REQ_READY), 32'h1);
    check("rd_oe_n", 32'(MEM_OE_n), 32'h0);
    check("rd_addr", 32'(MEM_ADDR), 32'h000100);
    REQ_VALID[0] = 1'b0;
    wait_rsp("rd_rsp_valid", 0);
    check("rd_rsp_dout", 32'(RSP_DOUT), 32'hA55A);
    check("rd_oe_n_after", 32'(MEM_OE_n), 32'h1);
    @(negedge CLK);
    check("rd_oe_len", oe_last, 32'd4);
    check("rd_rsp_pulse", 32'(RSP_VALID), 32'h0);

    // Write by requester 2; payload is scrubbed after grant to prove it was latched
    do_reset();
    hold = 1'b1;
    set_req(2, 1'b1, 23'h7FFFFE, 16'h1234);
    wait_ready("wr_ready", 2);
    REQ_ADDR[2*AW +: AW] = '0;
    REQ_DIN[2*DW +: DW]  = '0;
    check("wr_we_n", 32'(MEM_WE_n), 32'h0);
    check("wr_oe_n", 32'(MEM_OE_n), 32'h1);
    repeat (3) @(negedge CLK);
    check("wr_we_n_held", 32'(MEM_WE_n), 32'h0);
    check("wr_addr_held", 32'(MEM_ADDR), 32'h7FFFFE);
    check("wr_din_held", 32'(MEM_DIN), 32'h1234);
    hold = 1'b0;
    wait_rsp("wr_rsp_valid", 2);
    check("wr_we_n_after", 32'(MEM_WE_n), 32'h1);

    // Round-robin with all requesters asserting continuously
    do_reset();
    ack_delay = 1;
    evlog.delete();
    set_req(0, 1'b0, 23'h10, 16'h0);
    set_req(1, 1'b0, 23'h20, 16'h0);
    set_req(2, 1'b0, 23'h30, 16'h0);
    grants.delete();
    for (int n = 0; n < 300 && grants.size() < 6; n++) begin
      @(negedge CLK);
      grants.delete();
      foreach (evlog[k]) if (evlog[k] < 10) grants.push_back(evlog[k]);
    end
    REQ_VALID = '0;
    repeat (6) @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant%0d", k), (k < grants.size()) ? 32'(grants[k]) : 32'hFFFF,
            32'(k % 3));
    end

    // Refresh becomes due while requester 1 is in ACCESS and requester 0 waits
    do_reset();
    ack_delay = 2;
    hold      = 1'b1;
    evlog.delete();
    set_req(1, 1'b0, 23'h200, 16'h0);
    wait_ready("rp_ready1", 1);
    set_req(0, 1'b0, 23'h300, 16'h0);
    repeat (18) @(negedge CLK);
    check("rp_pend_due", 32'(dut.rfsh_pend), 32'd1);
    hold = 1'b0;
    wait_ready("rp_ready0", 0);
    check("rp_pend_clear", 32'(dut.rfsh_pend), 32'd0);
    wait_rsp("rp_rsp0", 0);
    exp_ev = '{1, 11, 20, 0, 10};
    for (int k = 0; k < 5; k++) begin
      got_ev = (k < evlog.size()) ? evlog[k] : -1;
      check($sformatf("rp_event%0d", k), 32'(got_ev), 32'(exp_ev[k]));
    end

    // Refresh saturation: no acks for five intervals
    do_reset();
    ack_delay = 1;
    hold      = 1'b1;
    evlog.delete();
    repeat (82) @(negedge CLK);
    check("sat_pend", 32'(dut.rfsh_pend), 32'd3);
    check("sat_rfsh_n_held", 32'(MEM_RFSH_n), 32'h0);
    hold = 1'b0;
    repeat (8) @(negedge CLK);
    check("sat_pend_drained", 32'(dut.rfsh_pend), 32'd0);
    n_rfsh = 0;
    foreach (evlog[k]) if (evlog[k] == 20) n_rfsh++;
    check("sat_rfsh_count", 32'(n_rfsh), 32'd3);
    check("sat_only_refresh", 32'(evlog.size()), 32'd3);
    check("sat_rfsh_n_idle", 32'(MEM_RFSH_n), 32'h1);

    // Reset during an access aborts it and restarts arbitration at requester 0
    do_reset();
    ack_delay = 2;
    set_req(0, 1'b0, 23'h40, 16'h0);
    wait_ready("ra_ready0", 0);
    wait_rsp("ra_rsp0", 0);
    hold = 1'b1;
    set_req(1, 1'b0, 23'h50, 16'h0);
    wait_ready("ra_ready1", 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("ra_oe_n", 32'(MEM_OE_n), 32'h1);
    check("ra_we_n", 32'(MEM_WE_n), 32'h1);
    check("ra_rfsh_n", 32'(MEM_RFSH_n), 32'h1);
    check("ra_rsp_valid", 32'(RSP_VALID), 32'h0);
    RESET = 1'b0;
    hold  = 1'b0;
    set_req(0, 1'b0, 23'h60, 16'h0);
    set_req(1, 1'b0, 23'h70, 16'h0);
    set_req(2, 1'b0, 23'h80, 16'h0);
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (REQ_READY != '0) break;
    end
    check("ra_first_grant", 32'(REQ_READY), 32'h1);
    REQ_VALID = '0;
    repeat (5) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
